// File: rtl/gray_ser_decoder.sv
// Bit-serial Gray-to-binary receiver with valid/ready output.
// GRAY_ADJ_CHECK_EN adds the Gray-adjacency flag on adj_err.
module gray_ser_decoder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             s_start,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             adj_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-2:0] bin_sr;
  logic             cap;
  logic             last;
  logic             rbit;
  logic [WIDTH-1:0] bin_nxt;

  // MSB starts the running XOR; the newest binary bit is bin_sr[0]
  assign cap = s_start &&
               ((state == IDLE) ||
                (state == HOLD && out_ready));
  assign last    = (cnt == CW'(WIDTH-1));
  assign rbit    = cap ? s_in : (bin_sr[0] ^ s_in);
  assign bin_nxt = {bin_sr, rbit};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bin_sr    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (cap || state == SHIFT)
        bin_sr <= bin_nxt[WIDTH-2:0];
      unique case (state)
        IDLE: begin
          if (s_start) begin
            state <= SHIFT;
            busy  <= 1'b1;
            cnt   <= CW'(1);
          end
        end
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            state     <= HOLD;
            cnt       <= '0;
            out       <= bin_nxt;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (s_start) begin
              state <= SHIFT;
              cnt   <= CW'(1);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef GRAY_ADJ_CHECK_EN
  logic [WIDTH-2:0] gray_sr;
  logic [WIDTH-1:0] gray_nxt;
  logic [WIDTH-1:0] rx_gray;
  logic [WIDTH-1:0] prev_gray;
  logic             first_word;

  assign gray_nxt = {gray_sr, s_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      gray_sr    <= '0;
      rx_gray    <= '0;
      prev_gray  <= '0;
      first_word <= 1'b1;
      adj_err    <= 1'b0;
    end else begin
      if (cap || state == SHIFT)
        gray_sr <= gray_nxt[WIDTH-2:0];
      if (state == SHIFT && last) begin
        rx_gray <= gray_nxt;
        adj_err <= !first_word &&
                   ($countones(gray_nxt ^ prev_gray) != 1);
      end else if (state == HOLD && out_ready) begin
        adj_err    <= 1'b0;
        prev_gray  <= rx_gray;
        first_word <= 1'b0;
      end
    end
  end
`else
  assign adj_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ser_decoder.sv
// Randomized scoreboard bench for gray_ser_decoder (WIDTH=4).
// Expected words come from a prefix-XOR Gray model.
module tb_gray_ser_decoder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_in;
  logic         s_start;
  logic         out_ready;
  logic [W-1:0] out;
  logic         out_valid;
  logic         adj_err;
  logic         busy;

  always #5 clk = ~clk;

  gray_ser_decoder #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .s_in(s_in),
    .s_start(s_start),
    .out(out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .adj_err(adj_err),
    .busy(busy)
  );

  typedef struct {
    logic [W-1:0] bin;
    logic         adj;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           passed = 0;
  int           cyc = 0;
  logic [W-1:0] m_prev = '0;
  bit           m_first = 1'b1;

  always @(posedge clk) cyc++;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  name, act, exp, cyc);
  endtask

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = '0;
    for (int s = 0; s < W; s++) b ^= g >> s;
    return b;
  endfunction

  function automatic logic exp_adj(input logic [W-1:0] g);
`ifdef GRAY_ADJ_CHECK_EN
    if (m_first) return 1'b0;
    return $countones(g ^ m_prev) != 1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    s_start = 1'b0;
    out_ready = 1'b0;
    s_in = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
    sb.delete();
    m_first = 1'b1;
    m_prev = '0;
    check("rst_out", out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_adj", adj_err, 0);
  endtask

  // DUT must be idle or holding; out_ready=1 on the MSB cycle
  task automatic send(input logic [W-1:0] g);
    exp_t e;
    e.bin = gray2bin(g);
    e.adj = exp_adj(g);
    e.due = cyc + W;
    sb.push_back(e);
    m_prev = g;
    m_first = 1'b0;
    for (int i = 0; i < W; i++) begin
      s_in = g[W-1-i];
      s_start = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      out_ready = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      out_ready = 1'b0;
      s_start = 1'($urandom_range(0, 1));
      s_in = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic accept_idle(input int n);
    out_ready = 1'b1;
    s_start = 1'b0;
    s_in = 1'($urandom_range(0, 1));
    tick();
    check("idle_busy", busy, 0);
    for (int i = 0; i < n; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      s_start = 1'b0;
      tick();
    end
  endtask

  // Monitor: pops on each new valid word, then checks it stays put
  exp_t cur;
  bit   seen = 1'b0;
  bit   acc = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
      acc = 1'b0;
    end else begin
      if (acc) check("valid_drop", out_valid, 0);
      if (out_valid) begin
        if (!seen) begin
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_valid: got out=%0h, expected no word",
                     out);
          end else begin
            cur = sb.pop_front();
            check("out", out, cur.bin);
            check("adj_err", adj_err, cur.adj);
            check("latency", cyc, cur.due);
            check("busy", busy, 1);
          end
          seen = 1'b1;
        end else begin
          check("hold_out", out, cur.bin);
          check("hold_adj", adj_err, cur.adj);
        end
      end else begin
        seen = 1'b0;
      end
      acc = out_valid && out_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    s_in = 1'b0;
    s_start = 1'b0;
    out_ready = 1'b0;
    do_reset(2);

    send(4'b0010);
    hold(2);
    send(4'b1000);
    send(4'b0100);
    accept_idle(2);

    do_reset(2);
    send(4'b0010);
    send(4'b0110);
    send(4'b0101);
    send(4'b0101);
    accept_idle(1);

    send(4'b0011);
    hold(6);
    send(4'b0001);
    accept_idle(1);

    s_start = 1'b1;
    s_in = 1'b1;
    tick();
    s_start = 1'b0;
    s_in = 1'b0;
    tick();
    do_reset(1);
    send(4'b1000);
    accept_idle(2);

    send(4'($urandom));
    for (int k = 0; k < 40; k++) begin
      hold($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        send(4'($urandom));
      end else begin
        accept_idle($urandom_range(0, 3));
        send(4'($urandom));
      end
    end
    hold($urandom_range(0, 2));
    accept_idle(1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check("drain", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
